// File: rtl/noc_host_injector.sv
// Host-side injector for the 3x3 ALU mesh: queues calculator requests, sends one flit at a
// time into tile (0,0), waits for the reply or a timeout, and returns the result by handshake.
module noc_host_injector #(
  parameter int REQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [3:0]  req_op,
  input  logic [1:0]  req_dst_x,
  input  logic [1:0]  req_dst_y,
  output logic [63:0] host_in_a,
  output logic [63:0] host_in_b,
  output logic [15:0] host_in_ctrl,
  output logic        host_in_valid,
  input  logic [63:0] host_out_a,
  input  logic        host_out_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  stray_cnt
);

  localparam int AW = $clog2(REQ_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [1:0]  dst_x;
    logic [1:0]  dst_y;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_INJECT, S_WAIT, S_RESP} state_t;

  state_t state_reg, state_next;

  req_t          fifo_mem [REQ_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] fill;
  logic          full, empty, push, pop, head_valid, illegal;
  req_t          incoming, head;

  logic [TW-1:0] timer_reg, timer_next;
  logic          timeout_hit;

  logic [63:0]   host_in_a_next, host_in_b_next, rsp_data_next;
  logic [15:0]   host_in_ctrl_next;
  logic          host_in_valid_next, rsp_valid_next, rsp_err_next;

  assign incoming = '{a: req_a, b: req_b, op: req_op, dst_x: req_dst_x, dst_y: req_dst_y};

  assign fill       = wr_ptr_reg - rd_ptr_reg;
  assign full       = (fill == PW'(REQ_DEPTH));
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign push       = req_valid && !full;
  // An empty FIFO forwards the request being pushed, so an idle injector fires on the next cycle.
  assign head_valid = !empty || push;
  assign head       = empty ? incoming : fifo_mem[rd_ptr_reg[AW-1:0]];
  assign pop        = (state_reg == S_IDLE) && head_valid;
  assign illegal    = (head.dst_x == 2'd3) || (head.dst_y == 2'd3);

  assign timeout_hit = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  assign req_ready = !full;
  assign busy      = (state_reg != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= incoming;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      timer_reg     <= '0;
      host_in_a     <= '0;
      host_in_b     <= '0;
      host_in_ctrl  <= '0;
      host_in_valid <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      host_in_a     <= host_in_a_next;
      host_in_b     <= host_in_b_next;
      host_in_ctrl  <= host_in_ctrl_next;
      host_in_valid <= host_in_valid_next;
      rsp_valid     <= rsp_valid_next;
      rsp_data      <= rsp_data_next;
      rsp_err       <= rsp_err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (pop) state_next = illegal ? S_RESP : S_INJECT;
      S_INJECT: state_next = host_out_valid ? S_RESP : S_WAIT;
      S_WAIT:   if (host_out_valid || timeout_hit) state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    timer_next         = timer_reg;
    host_in_a_next     = host_in_a;
    host_in_b_next     = host_in_b;
    host_in_ctrl_next  = host_in_ctrl;
    host_in_valid_next = 1'b0;
    rsp_valid_next     = rsp_valid;
    rsp_data_next      = rsp_data;
    rsp_err_next       = rsp_err;
    case (state_reg)
      S_IDLE: begin
        if (pop && illegal) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = '0;
          rsp_err_next   = 1'b1;
        end else if (pop) begin
          host_in_a_next     = head.a;
          host_in_b_next     = head.b;
          host_in_ctrl_next  = {7'd0, 1'b0, head.dst_x, head.dst_y, head.op};
          host_in_valid_next = 1'b1;
        end
      end
      S_INJECT: begin
        timer_next = '0;
        if (host_out_valid) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = host_out_a;
          rsp_err_next   = 1'b0;
        end
      end
      S_WAIT: begin
        timer_next = timer_reg + 1'b1;
        // A reply arriving on the last allowed cycle still counts as delivered.
        if (host_out_valid) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = host_out_a;
          rsp_err_next   = 1'b0;
        end else if (timeout_hit) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = '0;
          rsp_err_next   = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stray_cnt <= '0;
    end else if (host_out_valid && (state_reg == S_IDLE || state_reg == S_RESP)
                 && stray_cnt != 8'hFF) begin
      stray_cnt <= stray_cnt + 1'b1;
    end
  end

endmodule
